// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: next-PC select codes,
// the halt opcode and the fetch FSM state encoding.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        PC_SRC_SEQ    = 2'b00,
        PC_SRC_BRANCH = 2'b01,
        PC_SRC_REG    = 2'b10,
        PC_SRC_JUMP   = 2'b11
    } pc_src_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_FULL  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_HALT  = 3'd4
    } fetch_state_t;

    localparam logic [5:0] HALT_OPCODE = 6'b111111;

    function automatic logic is_halt(input logic [31:0] instr);
        return instr[31:26] == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/acknowledge channel between the fetch unit
// (master) and the instruction memory (slave).
interface fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_unit_next_pc.sv
// Combinational next-PC select: sequential, PC-relative branch, register
// target and pseudo-direct jump; all sums wrap at 32 bits.
module next_pc
    import fetch_unit_pkg::*;
(
    input  logic [31:0] pc4,
    input  logic [31:0] imm_ext,
    input  logic [31:0] rs_data,
    input  logic [25:0] jump_index,
    input  pc_src_t     src,
    output logic [31:0] pc_next
);

    always_comb begin
        pc_next = pc4;
        case (src)
            PC_SRC_SEQ:    pc_next = pc4;
            PC_SRC_BRANCH: pc_next = pc4 + {imm_ext[29:0], 2'b00};
            PC_SRC_REG:    pc_next = rs_data;
            PC_SRC_JUMP:   pc_next = {pc4[31:28], jump_index, 2'b00};
            default:       pc_next = pc4;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns PC and IR, runs the instruction memory
// handshake through a one-word fetch buffer and stalls IR loads until data arrives.
//
// state | meaning
// IDLE  | out of reset, fetch of PC starts next cycle
// FETCH | request outstanding, data will be kept
// FULL  | fetch buffer holds the word at PC
// FLUSH | request outstanding for a stale PC, data will be dropped
// HALT  | halt opcode loaded, frozen until reset
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic                CLK,
    input  logic                Reset,
    input  logic                PCWre,
    input  logic [1:0]          PCSrc,
    input  logic [31:0]         ImmExt,
    input  logic [31:0]         RsData,
    input  logic                IRWre,
    fetch_unit_if.master        imem,
    output logic [31:0]         PC,
    output logic [31:0]         PC4,
    output logic [31:0]         IR,
    output logic [5:0]          opcode,
    output logic                ir_valid,
    output logic                stall,
    output logic                halted
);

    fetch_state_t state;
    logic [31:0]  fetch_addr;
    logic [31:0]  buffer;
    logic         req_q;

    logic [31:0]  pc_next;
    logic         fetch_done;
    logic         ir_load;
    logic [31:0]  ir_src;
    logic         halt_load;
    logic         pc_load;
    logic [31:0]  pc_new;

    assign PC4       = PC + 32'd4;
    assign opcode    = IR[31:26];
    assign imem.req  = req_q;
    assign imem.addr = fetch_addr;

    next_pc u_next_pc (
        .pc4        (PC4),
        .imm_ext    (ImmExt),
        .rs_data    (RsData),
        .jump_index (IR[25:0]),
        .src        (pc_src_t'(PCSrc)),
        .pc_next    (pc_next)
    );

    // An acked word in FETCH can go straight into IR without passing through the buffer.
    always_comb begin
        fetch_done = (state == ST_FETCH) && imem.ack;
        ir_load    = IRWre && ((state == ST_FULL) || fetch_done);
        ir_src     = (state == ST_FULL) ? buffer : imem.rdata;
        halt_load  = ir_load && is_halt(ir_src);
        pc_load    = PCWre && (state != ST_HALT) && !halt_load;
        pc_new     = pc_load ? pc_next : PC;
    end

    assign stall = !Reset && IRWre && !ir_load && (state != ST_HALT);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state      <= ST_IDLE;
            PC         <= RESET_PC;
            IR         <= 32'h0000_0000;
            ir_valid   <= 1'b0;
            halted     <= 1'b0;
            req_q      <= 1'b0;
            fetch_addr <= RESET_PC;
            buffer     <= 32'h0000_0000;
        end else begin
            // IR takes the old buffer first; a same-cycle PC write then invalidates it.
            if (ir_load) begin
                IR       <= ir_src;
                ir_valid <= 1'b1;
            end
            if (pc_load) begin
                PC       <= pc_next;
                ir_valid <= 1'b0;
            end

            if (halt_load) begin
                state  <= ST_HALT;
                halted <= 1'b1;
                req_q  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state      <= ST_FETCH;
                        req_q      <= 1'b1;
                        fetch_addr <= pc_new;
                    end
                    ST_FETCH: begin
                        if (pc_load && imem.ack) begin
                            fetch_addr <= pc_new;
                        end else if (pc_load) begin
                            state <= ST_FLUSH;
                        end else if (imem.ack) begin
                            state  <= ST_FULL;
                            req_q  <= 1'b0;
                            buffer <= imem.rdata;
                        end
                    end
                    ST_FLUSH: begin
                        // Address must hold until the stale request completes.
                        if (imem.ack) begin
                            state      <= ST_FETCH;
                            fetch_addr <= pc_new;
                        end
                    end
                    ST_FULL: begin
                        if (pc_load) begin
                            state      <= ST_FETCH;
                            req_q      <= 1'b1;
                            fetch_addr <= pc_new;
                        end
                    end
                    ST_HALT: begin
                        state <= ST_HALT;
                    end
                    default: begin
                        state <= ST_IDLE;
                        req_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed stimulus, a flag-level model of the fetch
// pipeline checked every cycle, and literal expectations at key points.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        pcwre;
    logic [1:0]  pcsrc;
    logic [31:0] imm;
    logic [31:0] rsd;
    logic        irwre;
    logic [31:0] pc, pc4, ir;
    logic [5:0]  opcode;
    logic        ir_valid, stall, halted;

    logic        mem_ack = 1'b0;
    logic        stray_ack;
    logic [31:0] mem_rdata = 32'hDEAD_BEEF;
    int          mem_lat;
    int          wcnt = 0;
    logic [31:0] mem [logic [31:0]];

    int total = 0;
    int bad   = 0;

    fetch_unit_if mif ();
    assign mif.ack   = mem_ack | stray_ack;
    assign mif.rdata = mem_rdata;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .CLK      (clk),
        .Reset    (rst),
        .PCWre    (pcwre),
        .PCSrc    (pcsrc),
        .ImmExt   (imm),
        .RsData   (rsd),
        .IRWre    (irwre),
        .imem     (mif.master),
        .PC       (pc),
        .PC4      (pc4),
        .IR       (ir),
        .opcode   (opcode),
        .ir_valid (ir_valid),
        .stall    (stall),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0000_0000;
    endfunction

    // Memory: acks after mem_lat cycles of a continuously asserted request.
    initial begin
        forever begin
            @(negedge clk);
            if (rst || !mif.req) begin
                mem_ack   = 1'b0;
                mem_rdata = 32'hDEAD_BEEF;
                wcnt      = 0;
            end else if (wcnt + 1 >= mem_lat) begin
                mem_ack   = 1'b1;
                mem_rdata = rd(mif.addr);
                wcnt      = 0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 32'hDEAD_BEEF;
                wcnt      = wcnt + 1;
            end
        end
    end

    // Model: started = left reset idle, outstanding = memory request open,
    // drop = open request belongs to a superseded PC, has_word = buffered word for PC.
    logic [31:0] m_pc, m_ir, m_addr, m_word;
    logic        m_valid, m_halted, m_started, m_outstanding, m_drop, m_has_word;

    function automatic logic [31:0] f_next(input logic [31:0] p, input logic [1:0] s,
                                           input logic [31:0] i, input logic [31:0] r,
                                           input logic [31:0] instr);
        logic [31:0] p4;
        p4 = p + 32'd4;
        case (s)
            2'd0:    return p4;
            2'd1:    return p4 + i * 32'd4;
            2'd2:    return r;
            default: return (p4 & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) * 32'd4);
        endcase
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_ir = 32'h0; m_addr = 32'h0; m_word = 32'h0;
        m_valid = 1'b0; m_halted = 1'b0; m_started = 1'b0;
        m_outstanding = 1'b0; m_drop = 1'b0; m_has_word = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] nxt, wsrc;
        logic got, usable, load;
        if (m_halted) return;
        nxt = f_next(m_pc, pcsrc, imm, rsd, m_ir);
        if (!m_started) begin
            m_started = 1'b1;
            m_outstanding = 1'b1;
            if (pcwre) begin
                m_pc = nxt;
                m_valid = 1'b0;
            end
            m_addr = m_pc;
            return;
        end
        got    = m_outstanding && mif.ack;
        usable = got && !m_drop;
        wsrc   = m_has_word ? m_word : mif.rdata;
        load   = irwre && (m_has_word || usable);
        if (load && wsrc[31:26] == 6'h3F) begin
            m_ir = wsrc; m_valid = 1'b1; m_halted = 1'b1; m_outstanding = 1'b0;
            return;
        end
        if (load) begin
            m_ir = wsrc;
            m_valid = 1'b1;
        end
        if (pcwre) begin
            m_pc = nxt;
            m_valid = 1'b0;
            m_has_word = 1'b0;
            if (m_outstanding && !got) begin
                m_drop = 1'b1;
            end else begin
                m_outstanding = 1'b1;
                m_drop = 1'b0;
                m_addr = nxt;
            end
        end else if (got) begin
            if (m_drop) begin
                m_drop = 1'b0;
                m_addr = m_pc;
            end else begin
                m_outstanding = 1'b0;
                m_has_word = 1'b1;
                m_word = mif.rdata;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        logic exp_stall;
        forever begin
            @(negedge clk);
            #2;
            exp_stall = !rst && irwre && !m_halted &&
                        !(m_has_word || (m_outstanding && !m_drop && mif.ack));
            chk("pc", pc, m_pc);
            chk("pc4", pc4, m_pc + 32'd4);
            chk("ir", ir, m_ir);
            chk("opcode", {26'h0, opcode}, {26'h0, m_ir[31:26]});
            chk("ir_valid", {31'h0, ir_valid}, {31'h0, m_valid});
            chk("halted", {31'h0, halted}, {31'h0, m_halted});
            chk("imem_req", {31'h0, mif.req}, {31'h0, m_outstanding && !m_halted});
            chk("imem_addr", mif.addr, m_addr);
            chk("stall", {31'h0, stall}, {31'h0, exp_stall});
        end
    end

    task automatic pc_write(input logic [1:0] s, input logic [31:0] r, input logic [31:0] i);
        @(negedge clk);
        pcsrc = s; rsd = r; imm = i; pcwre = 1'b1;
        @(negedge clk);
        pcwre = 1'b0;
    endtask

    task automatic ir_pulse();
        @(negedge clk);
        irwre = 1'b1;
        @(negedge clk);
        irwre = 1'b0;
    endtask

    task automatic wait_full(input int budget);
        int n;
        n = 0;
        while (mif.req && n < budget) begin
            @(negedge clk);
            n = n + 1;
        end
        total = total + 1;
        if (mif.req) begin
            bad = bad + 1;
            $display("FAIL wait_full: req still %b after %0d cycles, required 0", mif.req, budget);
        end
    endtask

    initial begin
        rst = 1'b1; pcwre = 1'b0; pcsrc = 2'd0; imm = 32'h0; rsd = 32'h0;
        irwre = 1'b1; stray_ack = 1'b0; mem_lat = 1;
        mem[32'h0000_0000] = 32'h0000_0000;
        mem[32'h0000_0010] = 32'h1234_5678;
        mem[32'h2000_0000] = 32'hE000_0040;
        mem[32'h0000_0080] = 32'hAAAA_0001;
        mem[32'h0000_0100] = 32'h1111_2222;
        mem[32'h0000_0300] = 32'hFC00_0000;

        repeat (3) @(negedge clk);
        #3;
        chk("rst_pc", pc, 32'h0);
        chk("rst_req", {31'h0, mif.req}, 32'h0);
        chk("rst_addr", mif.addr, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);

        // Out of reset: request at cycle 1, buffer full at cycle 2.
        @(negedge clk);
        irwre = 1'b0; rst = 1'b0;
        @(negedge clk); #3;
        chk("c1_req", {31'h0, mif.req}, 32'h1);
        chk("c1_addr", mif.addr, 32'h0);
        @(negedge clk); #3;
        chk("c2_req", {31'h0, mif.req}, 32'h0);
        ir_pulse(); #3;
        chk("first_ir", ir, 32'h0);
        chk("first_valid", {31'h0, ir_valid}, 32'h1);

        // Backward branch from 0x10.
        pc_write(2'd2, 32'h10, 32'h0); #3;
        chk("set_pc10", pc, 32'h10);
        wait_full(20);
        pc_write(2'd1, 32'h0, 32'hFFFF_FFFE); #3;
        chk("branch_pc", pc, 32'h0C);
        chk("branch_addr", mif.addr, 32'h0C);
        chk("branch_req", {31'h0, mif.req}, 32'h1);
        wait_full(20);

        // Jump and jump-register.
        pc_write(2'd2, 32'h2000_0000, 32'h0);
        wait_full(20);
        ir_pulse(); #3;
        chk("jmp_ir", ir, 32'hE000_0040);
        pc_write(2'd3, 32'h0, 32'h0); #3;
        chk("jump_pc", pc, 32'h2000_0100);
        wait_full(20);
        pc_write(2'd2, 32'h44, 32'h0); #3;
        chk("jr_pc", pc, 32'h44);
        wait_full(20);

        // Slow memory: redirect while waiting, stale word must be dropped.
        mem_lat = 3;
        pc_write(2'd2, 32'h80, 32'h0);
        pc_write(2'd2, 32'h100, 32'h0); #3;
        chk("flush_addr", mif.addr, 32'h80);
        chk("flush_pc", pc, 32'h100);
        @(negedge clk);
        irwre = 1'b1;
        #3;
        chk("refetch_addr", mif.addr, 32'h100);
        chk("wait_stall", {31'h0, stall}, 32'h1);
        begin
            int n;
            n = 0;
            while (!ir_valid && n < 20) begin
                @(negedge clk);
                n = n + 1;
            end
        end
        irwre = 1'b0;
        #3;
        chk("flush_ir", ir, 32'h1111_2222);
        chk("flush_valid", {31'h0, ir_valid}, 32'h1);

        // PC+4 wraps.
        mem_lat = 1;
        pc_write(2'd2, 32'hFFFF_FFFC, 32'h0);
        wait_full(20);
        pc_write(2'd0, 32'h0, 32'h0); #3;
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_pc4", pc4, 32'h4);
        wait_full(20);

        // Reset mid-handshake, then a stray ack while idle.
        mem_lat = 3;
        pc_write(2'd2, 32'h200, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #3;
        chk("midrst_req", {31'h0, mif.req}, 32'h0);
        chk("midrst_pc", pc, 32'h0);
        @(negedge clk);
        stray_ack = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        stray_ack = 1'b0;
        #3;
        chk("stray_req", {31'h0, mif.req}, 32'h1);
        chk("stray_addr", mif.addr, 32'h0);
        wait_full(20);
        mem_lat = 1;

        // Halt opcode freezes PC and IR until reset.
        pc_write(2'd2, 32'h300, 32'h0);
        wait_full(20);
        ir_pulse(); #3;
        chk("halt_flag", {31'h0, halted}, 32'h1);
        chk("halt_req", {31'h0, mif.req}, 32'h0);
        chk("halt_ir", ir, 32'hFC00_0000);
        pc_write(2'd2, 32'h500, 32'h0); #3;
        chk("halt_pc_reg", pc, 32'h300);
        pc_write(2'd1, 32'h0, 32'h8); #3;
        chk("halt_pc_br", pc, 32'h300);
        @(negedge clk);
        irwre = 1'b1;
        #3;
        chk("halt_stall", {31'h0, stall}, 32'h0);
        @(negedge clk);
        irwre = 1'b0;
        rst = 1'b1;
        #3;
        chk("unhalt", {31'h0, halted}, 32'h0);
        chk("unhalt_pc", pc, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have port CLK  input  1  system clock; all state updates occur on the rising edge.
REQ-003 SHALL have port Reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port PCWre  input  1  PC write enable from the control unit.
REQ-005 SHALL have port PCSrc  input  2  next-PC select: 00 PC+4, 01 branch, 10 RsData, 11 jump.
REQ-006 SHALL have port ImmExt  input  32  extended immediate (branch offset in words).
REQ-007 SHALL have port RsData  input  32  register rs value, used for the jump-register target.
REQ-008 SHALL have port IRWre  input  1  instruction-register load request from the control unit.
REQ-009 SHALL have ports imem_req out 1, imem_addr out 32, imem_ack in 1, imem_rdata in 32, forming the instruction memory request/acknowledge handshake.
REQ-010 SHALL have outputs PC 32, PC4 32, IR 32, opcode 6 (IR[31:26]), ir_valid 1, stall 1, halted 1.

Function
REQ-011 FSM states SHALL be IDLE, FETCH, FULL, FLUSH and HALT; reset state is IDLE.
REQ-012 IDLE SHALL go to FETCH after one cycle.
REQ-013 In FETCH and FLUSH, imem_req SHALL be 1 and imem_addr SHALL stay stable until imem_ack; imem_req SHALL be 0 in all other states.
REQ-014 FETCH SHALL go to FULL on imem_ack, latching imem_rdata into the fetch buffer.
REQ-015 FLUSH SHALL discard the data returned with imem_ack and then go to FETCH.
REQ-016 imem_addr SHALL equal the fetch address register, which is loaded with PC whenever a fetch starts.
REQ-017 IR load: when IRWre=1 and state=FULL, IR SHALL take the buffer contents at the next edge, and ir_valid SHALL be set to 1.
REQ-018 When IRWre=1 with the buffer not FULL, stall SHALL be 1 (combinational), IR SHALL hold, and the control unit holds its state.
REQ-019 On IRWre=1 in FETCH with imem_ack=1 in the same cycle, imem_rdata SHALL bypass into IR, the state SHALL go to FULL, and stall SHALL be 0.
REQ-020 PC4 SHALL be PC+4 (combinational), computed modulo 2^32.
REQ-021 Next PC by PCSrc: 00 PC4; 01 PC4+(ImmExt<<2); 10 RsData; 11 {PC4[31:28], IR[25:0], 2'b00}; all arithmetic is 32-bit and wraps.
REQ-022 PCWre=1 (not halted) SHALL load next PC, clear ir_valid, and start a fetch of the new PC.
REQ-023 On PCWre=1 from FULL or IDLE, the next state SHALL be FETCH.
REQ-024 On PCWre=1 from FETCH without imem_ack, the next state SHALL be FLUSH, keeping the old address until ack.
REQ-025 On PCWre=1 from FETCH with imem_ack in the same cycle, the next state SHALL be FETCH and the returned data SHALL be dropped.
REQ-026 When IR is loaded with opcode 6'b111111, the next state SHALL be HALT and halted SHALL be 1.
REQ-027 In HALT, PCWre and IRWre SHALL be ignored, and PC and IR SHALL hold; only Reset exits HALT.
REQ-028 Simultaneous PCWre and IRWre SHALL apply IRWre to the old buffer first; the PCWre flush takes priority for the FSM.

Reset
REQ-029 While Reset=1: PC=RESET_PC, IR=0, ir_valid=0, halted=0, imem_req=0, imem_addr=RESET_PC, stall=0, state=IDLE.
REQ-030 Reset asserted mid-handshake SHALL abandon the request without waiting for imem_ack; a later stray ack in IDLE SHALL be ignored.

Structure
REQ-031 The shared package SHALL hold the PCSrc encodings, the HALT opcode 6'b111111 and the FSM state encoding.
REQ-032 A single sub-module, next_pc, SHALL implement the combinational next-PC mux of REQ-021.

Verification
REQ-033 Reset release, memory acking in 1 cycle with word 32'h0000_0000 at address 0 -> imem_req at cycle 1, addr 0, FULL at cycle 2; IRWre gives IR=0, ir_valid=1.
REQ-034 PC=0x10, PCSrc=01, ImmExt=0xFFFF_FFFE, PCWre -> PC=0x0C and a new fetch at 0x0C.
REQ-035 IR=0xE000_0040, PC=0x2000_0000, PCSrc=11 -> PC=0x2000_0100; PCSrc=10 with RsData=0x44 -> PC=0x44.
REQ-036 Memory ack delayed 3 cycles, PCWre in the wait -> FLUSH, first ack data not loaded, second fetch at the new PC; IRWre meanwhile gives stall=1.
REQ-037 Load of IR=0xFC00_0000 -> halted=1, imem_req=0, and PCWre pulses leave PC unchanged until Reset.
REQ-038 PC=0xFFFF_FFFC, PCSrc=00, PCWre -> PC=0x0000_0000 (wrap).
